// File: rtl/x4xx_ctrlport_timeout_guard.sv
// Single-outstanding ctrlport guard: registers requests to the core, returns
// a CMDERR ack when the core stays silent, and counts protocol anomalies.
module x4xx_ctrlport_timeout_guard #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             ctrlport_clk,
  input  logic             ctrlport_rst,
  input  logic             s_ctrlport_req_wr,
  input  logic             s_ctrlport_req_rd,
  input  logic [19:0]      s_ctrlport_req_addr,
  input  logic [31:0]      s_ctrlport_req_data,
  output logic             s_ctrlport_resp_ack,
  output logic [1:0]       s_ctrlport_resp_status,
  output logic [31:0]      s_ctrlport_resp_data,
  output logic             m_ctrlport_req_wr,
  output logic             m_ctrlport_req_rd,
  output logic [19:0]      m_ctrlport_req_addr,
  output logic [31:0]      m_ctrlport_req_data,
  input  logic             m_ctrlport_resp_ack,
  input  logic [1:0]       m_ctrlport_resp_status,
  input  logic [31:0]      m_ctrlport_resp_data,
  input  logic             clear_counters,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] stray_ack_count,
  output logic [CNT_W-1:0] overlap_count,
  output logic [19:0]      last_timeout_addr
);

  localparam logic [15:0]      TO_LIM  = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]       STS_ERR = 2'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t      r_state;
  logic [15:0] r_wait;

  logic w_req;
  logic w_busy;
  logic w_fin_ack;
  logic w_timeout;
  logic w_accept;
  logic w_overlap;
  logic w_stray;

  assign w_req     = s_ctrlport_req_wr | s_ctrlport_req_rd;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_fin_ack = w_busy & m_ctrlport_resp_ack;
  // A real ack in the expiry cycle takes precedence over the timeout
  assign w_timeout = w_busy & ~m_ctrlport_resp_ack & (r_wait == TO_LIM);
  assign w_accept  = w_req & (~w_busy | w_fin_ack | w_timeout);
  assign w_overlap = w_req & w_busy & ~w_fin_ack & ~w_timeout;
  assign w_stray   = ~w_busy & m_ctrlport_resp_ack;

  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      r_state                <= ST_IDLE;
      r_wait                 <= '0;
      m_ctrlport_req_wr      <= 1'b0;
      m_ctrlport_req_rd      <= 1'b0;
      m_ctrlport_req_addr    <= '0;
      m_ctrlport_req_data    <= '0;
      s_ctrlport_resp_ack    <= 1'b0;
      s_ctrlport_resp_status <= '0;
      s_ctrlport_resp_data   <= '0;
      last_timeout_addr      <= '0;
    end else begin
      m_ctrlport_req_wr   <= 1'b0;
      m_ctrlport_req_rd   <= 1'b0;
      s_ctrlport_resp_ack <= 1'b0;
      if (w_busy) begin
        r_wait <= r_wait + 16'd1;
      end
      if (w_fin_ack) begin
        s_ctrlport_resp_ack    <= 1'b1;
        s_ctrlport_resp_status <= m_ctrlport_resp_status;
        s_ctrlport_resp_data   <= m_ctrlport_resp_data;
        r_state                <= ST_IDLE;
      end else if (w_timeout) begin
        s_ctrlport_resp_ack    <= 1'b1;
        s_ctrlport_resp_status <= STS_ERR;
        s_ctrlport_resp_data   <= '0;
        last_timeout_addr      <= m_ctrlport_req_addr;
        r_state                <= ST_IDLE;
      end
      if (w_accept) begin
        m_ctrlport_req_wr   <= s_ctrlport_req_wr;
        m_ctrlport_req_rd   <= s_ctrlport_req_rd;
        m_ctrlport_req_addr <= s_ctrlport_req_addr;
        m_ctrlport_req_data <= s_ctrlport_req_data;
        r_wait              <= '0;
        r_state             <= ST_BUSY;
      end
    end
  end

  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      timeout_count   <= '0;
      stray_ack_count <= '0;
      overlap_count   <= '0;
    end else if (clear_counters) begin
      timeout_count   <= '0;
      stray_ack_count <= '0;
      overlap_count   <= '0;
    end else begin
      if (w_timeout && timeout_count != CNT_MAX) begin
        timeout_count <= timeout_count + 1'b1;
      end
      if (w_stray && stray_ack_count != CNT_MAX) begin
        stray_ack_count <= stray_ack_count + 1'b1;
      end
      if (w_overlap && overlap_count != CNT_MAX) begin
        overlap_count <= overlap_count + 1'b1;
      end
    end
  end

endmodule
